// File: rtl/title_screen_sequencer.sv
// Title-screen sequencer: slides the title in, blinks the start prompt, fades out,
// then pulses game_start. All outputs are registered; restart behaves like reset.
module title_screen_sequencer #(
  parameter int START_Y      = -128,
  parameter int FINAL_Y      = 32,
  parameter int SLIDE_STEP   = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int FADE_FRAMES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               restart,
  output logic signed [31:0] title_margin_y,
  output logic               title_enable,
  output logic               prompt_enable,
  output logic [3:0]         fade_level,
  output logic               game_start,
  output logic [2:0]         state
);

  // state | meaning
  // IDLE  | title hidden above screen, waiting for the first frame
  // SLIDE | title moving down SLIDE_STEP pixels per frame
  // WAIT  | title at rest, prompt blinking, waiting for start
  // FADE  | brightness stepping down toward black
  // DONE  | sequence finished, game running
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLIDE = 3'd1,
    WAIT  = 3'd2,
    FADE  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CNT_MAX = (BLINK_FRAMES > FADE_FRAMES) ? BLINK_FRAMES : FADE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] FADE_LOAD  = CNT_W'(FADE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t             state_q, state_d;
  logic signed [31:0] margin_d, margin_step;
  logic               title_d, prompt_d, game_start_d;
  logic [3:0]         fade_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_edge;

  assign start_edge  = start_btn & ~start_q;
  assign margin_step = title_margin_y + SLIDE_STEP;
  assign state       = state_q;

  always_comb begin
    state_d      = state_q;
    margin_d     = title_margin_y;
    title_d      = title_enable;
    prompt_d     = prompt_enable;
    fade_d       = fade_level;
    game_start_d = 1'b0;
    cnt_d        = cnt_q;

    if (restart) begin
      state_d  = IDLE;
      margin_d = START_Y;
      title_d  = 1'b0;
      prompt_d = 1'b0;
      fade_d   = 4'd15;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_d = SLIDE;
            title_d = 1'b1;
          end
        end
        SLIDE: begin
          // A start press skips the rest of the slide but does not start the fade.
          if (start_edge || (frame_tick && (margin_step >= FINAL_Y))) begin
            state_d  = WAIT;
            margin_d = FINAL_Y;
            prompt_d = 1'b1;
            cnt_d    = BLINK_LOAD;
          end else if (frame_tick) begin
            margin_d = margin_step;
          end
        end
        WAIT: begin
          if (start_edge) begin
            state_d  = FADE;
            prompt_d = 1'b0;
            cnt_d    = FADE_LOAD;
          end else if (frame_tick) begin
            if (cnt_q == '0) begin
              cnt_d    = BLINK_LOAD;
              prompt_d = ~prompt_enable;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        FADE: begin
          if (frame_tick) begin
            if (cnt_q == '0) begin
              cnt_d = FADE_LOAD;
              if (fade_level != 4'd0) fade_d = fade_level - 4'd1;
              if (fade_level <= 4'd1) begin
                state_d      = DONE;
                title_d      = 1'b0;
                game_start_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        DONE: begin
          margin_d = FINAL_Y;
          title_d  = 1'b0;
          prompt_d = 1'b0;
          fade_d   = 4'd0;
        end
        default: begin
          state_d  = IDLE;
          margin_d = START_Y;
          title_d  = 1'b0;
          prompt_d = 1'b0;
          fade_d   = 4'd15;
          cnt_d    = '0;
        end
      endcase
    end
  end

  // start_q resets high so a button held through reset never counts as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      title_margin_y <= START_Y;
      title_enable   <= 1'b0;
      prompt_enable  <= 1'b0;
      fade_level     <= 4'd15;
      game_start     <= 1'b0;
      cnt_q          <= '0;
      start_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      title_margin_y <= margin_d;
      title_enable   <= title_d;
      prompt_enable  <= prompt_d;
      fade_level     <= fade_d;
      game_start     <= game_start_d;
      cnt_q          <= cnt_d;
      start_q        <= start_btn;
    end
  end

endmodule

// File: tb/tb_title_screen_sequencer.sv
// Bench for title_screen_sequencer: directed scenarios plus random stimulus, with a
// phase/frame-count reference model compared against the DUT every cycle.
module tb_title_screen_sequencer;

  localparam int START_Y = -128;
  localparam int FINAL_Y = 32;
  localparam int STEP    = 2;
  localparam int BLINK   = 30;
  localparam int FADEF   = 4;

  logic               clk = 1'b0;
  logic               reset, frame_tick, start_btn, restart;
  logic signed [31:0] title_margin_y;
  logic               title_enable, prompt_enable, game_start;
  logic [3:0]         fade_level;
  logic [2:0]         state;

  int n_cmp = 0;
  int n_err = 0;
  int gs_seen = 0;
  bit go = 0;

  // Model: current phase (0..4), frames elapsed in that phase, start sampler, pulse.
  int ph = 0;
  int tk = 0;
  bit m_sq = 1;
  bit m_gs = 0;
  bit m_edge;

  title_screen_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .restart(restart), .title_margin_y(title_margin_y), .title_enable(title_enable),
    .prompt_enable(prompt_enable), .fade_level(fade_level), .game_start(game_start),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      ph = 0; tk = 0; m_sq = 1; m_gs = 0;
    end else begin
      m_edge = start_btn && !m_sq;
      m_sq   = start_btn;
      m_gs   = 0;
      if (restart) begin
        ph = 0; tk = 0;
      end else begin
        case (ph)
          0: if (frame_tick) begin ph = 1; tk = 0; end
          1: if (m_edge) begin ph = 2; tk = 0; end
             else if (frame_tick) begin
               tk++;
               if (START_Y + STEP * tk >= FINAL_Y) begin ph = 2; tk = 0; end
             end
          2: if (m_edge) begin ph = 3; tk = 0; end
             else if (frame_tick) tk++;
          3: if (frame_tick) begin
               tk++;
               if (tk == 15 * FADEF) begin ph = 4; m_gs = 1; end
             end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      int  e_margin, e_fade;
      bit  e_prompt, e_title;
      e_margin = (ph == 0) ? START_Y : (ph == 1) ? START_Y + STEP * tk : FINAL_Y;
      e_prompt = (ph == 2) && (((tk / BLINK) % 2) == 0);
      e_fade   = (ph == 3) ? 15 - tk / FADEF : (ph == 4) ? 0 : 15;
      e_title  = (ph >= 1) && (ph <= 3);
      check("state", state, ph);
      check("margin", title_margin_y, e_margin);
      check("title_en", title_enable, e_title);
      check("prompt_en", prompt_enable, e_prompt);
      check("fade", fade_level, e_fade);
      check("game_start", game_start, m_gs);
      if (game_start) gs_seen++;
    end
  end

  task automatic cyc(input bit ft, input bit b, input bit rs, input bit rr);
    frame_tick = ft; start_btn = b; reset = rs; restart = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n, input bit b);
    repeat (n) begin
      cyc(1, b, 0, 0);
      cyc(0, b, 0, 0);
    end
  endtask

  initial begin
    bit b;
    // Button held high from reset: slide runs but never fades.
    cyc(0, 1, 1, 0);
    go = 1;
    cyc(0, 1, 1, 0);
    check("rst_state", state, 0);
    check("rst_margin", title_margin_y, -128);
    check("rst_fade", fade_level, 15);
    cyc(0, 1, 0, 0);
    frames(1, 1);
    check("t1_state", state, 1);
    check("t1_title", title_enable, 1);
    check("t1_margin", title_margin_y, -128);
    frames(80, 1);
    check("t81_margin", title_margin_y, 32);
    check("t81_state", state, 2);
    check("t81_prompt", prompt_enable, 1);
    frames(30, 1);
    check("blink30", prompt_enable, 0);
    frames(30, 1);
    check("blink60", prompt_enable, 1);
    frames(30, 1);
    check("blink90", prompt_enable, 0);
    frames(29, 1);
    check("held_no_fade", state, 2);

    // Press start in WAIT, fade to DONE.
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("fade_state", state, 3);
    check("fade_prompt", prompt_enable, 0);
    frames(4, 1);
    check("fade_14", fade_level, 14);
    frames(55, 1);
    check("fade_1", fade_level, 1);
    cyc(1, 1, 0, 0);
    check("gs_high", game_start, 1);
    check("done_state", state, 4);
    check("done_title", title_enable, 0);
    check("done_fade", fade_level, 0);
    cyc(0, 1, 0, 0);
    check("gs_low", game_start, 0);
    repeat (1000) cyc(1'($urandom % 2), 1'($urandom % 2), 0, 0);
    check("gs_count1", gs_seen, 1);
    check("done_hold", state, 4);

    // Restart, skip slide with a press coincident with a tick.
    cyc(0, 0, 0, 1);
    check("rr_state", state, 0);
    cyc(0, 0, 0, 0);
    frames(10, 0);
    check("slide10_margin", title_margin_y, -110);
    cyc(1, 1, 0, 0);
    check("skip_margin", title_margin_y, 32);
    check("skip_state", state, 2);
    check("skip_fade", fade_level, 15);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    frames(32, 1);
    check("fade_7", fade_level, 7);
    cyc(0, 1, 0, 1);
    check("rr2_state", state, 0);
    check("rr2_margin", title_margin_y, -128);
    check("rr2_fade", fade_level, 15);
    check("rr2_title", title_enable, 0);
    frames(81, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    frames(60, 1);
    check("gs_count2", gs_seen, 2);
    check("rerun_done", state, 4);

    // Reset mid-slide coincident with tick and start edge.
    cyc(0, 0, 0, 1);
    frames(5, 0);
    check("pre_rst_state", state, 1);
    cyc(1, 1, 1, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_margin", title_margin_y, -128);
    check("mid_rst_gs", game_start, 0);
    check("mid_rst_title", title_enable, 0);
    frames(3, 1);

    // Random traffic against the model.
    b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 16 == 0) b = ~b;
      cyc(1'($urandom % 3 == 0), b, 1'($urandom % 700 == 0), 1'($urandom % 400 == 0));
    end

    go = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
